// File: rtl/mem_access.sv
// Memory stage of the RV32I datapath: one load or store per access over a
// request/grant/response port, with store lane steering, load extension and fault reporting.
module mem_access #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_res,
  input  logic [31:0] rs2_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data,
  output logic        done,
  output logic        stall,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is held with all fields stable while dmem_req=1 and
  // retires on the cycle dmem_gnt=1; read data is taken only when dmem_rvalid=1 in WAIT_R.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2
  } state_t;

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  state_t        state_q, state_d;
  logic          dmem_req_q, dmem_req_d;
  logic          dmem_we_q, dmem_we_d;
  logic [31:0]   dmem_addr_q, dmem_addr_d;
  logic [3:0]    dmem_be_q, dmem_be_d;
  logic [31:0]   dmem_wdata_q, dmem_wdata_d;
  logic [31:0]   load_data_q, load_data_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;
  logic [1:0]    fault_cause_q, fault_cause_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;

  logic          accept, f3_legal, misaligned, go, expired;
  logic [3:0]    st_be;
  logic [31:0]   st_wdata;
  logic [31:0]   rd_shift;
  logic [31:0]   ld_ext;

  always_comb begin
    accept = (state_q == S_IDLE) && ex_valid && (mem_read || mem_write);

    if (mem_write) f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else           f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                              (funct3 == 3'b100) || (funct3 == 3'b101);

    misaligned = ((funct3[1:0] == 2'b01) && alu_res[0]) ||
                 ((funct3[1:0] == 2'b10) && (alu_res[1:0] != 2'b00));
    go = accept && f3_legal && !misaligned;

    case (funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << alu_res[1:0];
        st_wdata = {4{rs2_data[7:0]}};
      end
      2'b01: begin
        st_be    = alu_res[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{rs2_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = rs2_data;
      end
    endcase

    // Bring the addressed lane down to bit 0 before extending.
    rd_shift = dmem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_ext = {24'd0, rd_shift[7:0]};
      3'b101:  ld_ext = {16'd0, rd_shift[15:0]};
      default: ld_ext = dmem_rdata;
    endcase

    expired = (wait_cnt_q == CNT_LAST);
  end

  always_comb begin
    state_d       = state_q;
    dmem_req_d    = dmem_req_q;
    dmem_we_d     = dmem_we_q;
    dmem_addr_d   = dmem_addr_q;
    dmem_be_d     = dmem_be_q;
    dmem_wdata_d  = dmem_wdata_q;
    load_data_d   = load_data_q;
    done_d        = 1'b0;
    fault_d       = 1'b0;
    fault_cause_d = 2'b00;
    wait_cnt_d    = wait_cnt_q;
    f3_d          = f3_q;
    off_d         = off_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!f3_legal) begin
            done_d        = 1'b1;
            fault_d       = 1'b1;
            fault_cause_d = 2'b10;
          end else if (misaligned) begin
            done_d        = 1'b1;
            fault_d       = 1'b1;
            fault_cause_d = 2'b01;
          end else begin
            dmem_req_d   = 1'b1;
            dmem_we_d    = mem_write;
            dmem_addr_d  = {alu_res[31:2], 2'b00};
            dmem_be_d    = mem_write ? st_be : 4'b1111;
            dmem_wdata_d = mem_write ? st_wdata : 32'd0;
            f3_d         = funct3;
            off_d        = alu_res[1:0];
            wait_cnt_d   = '0;
            state_d      = S_REQ;
          end
        end
      end
      S_REQ: begin
        wait_cnt_d = wait_cnt_q + CW'(1);
        // A grant in the expiry cycle still completes the access.
        if (dmem_gnt) begin
          dmem_req_d = 1'b0;
          if (dmem_we_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_R;
          end
        end else if (expired) begin
          dmem_req_d    = 1'b0;
          done_d        = 1'b1;
          fault_d       = 1'b1;
          fault_cause_d = 2'b11;
          load_data_d   = 32'd0;
          state_d       = S_IDLE;
        end
      end
      S_WAIT_R: begin
        wait_cnt_d = wait_cnt_q + CW'(1);
        if (dmem_rvalid) begin
          load_data_d = ld_ext;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end else if (expired) begin
          done_d        = 1'b1;
          fault_d       = 1'b1;
          fault_cause_d = 2'b11;
          load_data_d   = 32'd0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= 32'd0;
      dmem_be_q     <= 4'd0;
      dmem_wdata_q  <= 32'd0;
      load_data_q   <= 32'd0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
      fault_cause_q <= 2'b00;
      wait_cnt_q    <= '0;
      f3_q          <= 3'd0;
      off_q         <= 2'd0;
    end else begin
      state_q       <= state_d;
      dmem_req_q    <= dmem_req_d;
      dmem_we_q     <= dmem_we_d;
      dmem_addr_q   <= dmem_addr_d;
      dmem_be_q     <= dmem_be_d;
      dmem_wdata_q  <= dmem_wdata_d;
      load_data_q   <= load_data_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
      fault_cause_q <= fault_cause_d;
      wait_cnt_q    <= wait_cnt_d;
      f3_q          <= f3_d;
      off_q         <= off_d;
    end
  end

  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_be     = dmem_be_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign load_data   = load_data_q;
  assign done        = done_q;
  assign fault       = fault_q;
  assign fault_cause = fault_cause_q;
  assign stall       = (state_q != S_IDLE) || go;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: table of single accesses with scripted memory timing,
// random byte loads, and reset-in-flight sequences.
module tb_mem_access;

  logic        clk;
  logic        rst_n;
  logic        ex_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_res, rs2_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] load_data;
  logic        done, stall, fault;
  logic [1:0]  fault_cause;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [34:0] exp_q[$];

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          gnt_cyc;
    int          rv_cyc;
    int          done_cyc;
    int          req_cyc;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_load;
    logic        e_fault;
    logic [1:0]  e_cause;
  } vec_t;

  vec_t vecs[15];

  mem_access #(.MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .alu_res(alu_res), .rs2_data(rs2_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .load_data(load_data), .done(done), .stall(stall),
    .fault(fault), .fault_cause(fault_cause), .dbg_state(dbg_state)
  );

  // Clock and run-time bound.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "bench time limit reached");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    funct3      = 3'd0;
    alu_res     = 32'd0;
    rs2_data    = 32'd0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'd0;
  endtask

  task automatic drive_access(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] rs2);
    @(negedge clk);
    ex_valid  = 1'b1;
    mem_write = st;
    mem_read  = !st;
    funct3    = f3;
    alu_res   = addr;
    rs2_data  = rs2;
  endtask

  // One access: drive at cycle 0, play memory per the vector, score on done.
  task automatic run_vec(input vec_t v);
    int          req_seen;
    int          stall_seen;
    int          done_at;
    bit          fields_ok;
    bit          got;
    logic [34:0] e;
    req_seen   = 0;
    stall_seen = 0;
    done_at    = 0;
    fields_ok  = 1'b1;
    got        = 1'b0;
    drive_access(v.st, v.f3, v.addr, v.rs2);
    #1;
    chk("stall_accept", {31'd0, stall}, {31'd0, v.req_cyc != 0});
    exp_q.push_back({v.e_fault, v.e_cause, v.e_load});
    @(posedge clk);
    #1;
    ex_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    for (int cyc = 1; cyc <= 20 && !got; cyc++) begin
      @(negedge clk);
      if (dmem_req) begin
        req_seen++;
        if (dmem_addr !== v.e_addr || dmem_be !== v.e_be || dmem_wdata !== v.e_wdata ||
            dmem_we !== v.st)
          fields_ok = 1'b0;
      end
      if (stall) stall_seen++;
      dmem_gnt    = (cyc == v.gnt_cyc);
      dmem_rvalid = (cyc == v.rv_cyc);
      dmem_rdata  = v.rdata;
      if (done) begin
        got     = 1'b1;
        done_at = cyc;
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("fault", {31'd0, fault}, {31'd0, e[34]});
          chk("fault_cause", {30'd0, fault_cause}, {30'd0, e[33:32]});
          chk("load_data", load_data, e[31:0]);
        end
      end
    end
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    chk("done_cycle", done_at, v.done_cyc);
    chk("req_cycles", req_seen, v.req_cyc);
    chk("stall_cycles", stall_seen, (v.req_cyc == 0) ? 0 : v.done_cyc - 1);
    if (v.req_cyc != 0) chk("req_fields", {31'd0, fields_ok}, 32'd1);
    @(negedge clk);
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    chk("done_pulse", {30'd0, done, fault}, 32'd0);
    chk("state_idle", {30'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    vec_t        rv;
    int          off;
    bit          sgn;
    logic [31:0] rd;
    logic [7:0]  b;
    int          late_done;

    // st f3 addr rs2 rdata gnt rv done req e_addr e_be e_wdata e_load e_fault e_cause
    vecs[0]  = '{1'b1, 3'b000, 32'h1003, 32'h000000A5, 32'h0, 1, 0, 2, 1,
                 32'h1000, 4'b1000, 32'hA5A5A5A5, 32'h0, 1'b0, 2'b00};
    vecs[1]  = '{1'b0, 3'b000, 32'h2002, 32'h0, 32'h1280FF34, 1, 2, 3, 1,
                 32'h2000, 4'b1111, 32'h0, 32'hFFFFFF80, 1'b0, 2'b00};
    vecs[2]  = '{1'b0, 3'b100, 32'h2002, 32'h0, 32'h1280FF34, 1, 2, 3, 1,
                 32'h2000, 4'b1111, 32'h0, 32'h00000080, 1'b0, 2'b00};
    vecs[3]  = '{1'b0, 3'b001, 32'h2002, 32'h0, 32'h1280FF34, 1, 2, 3, 1,
                 32'h2000, 4'b1111, 32'h0, 32'h00001280, 1'b0, 2'b00};
    vecs[4]  = '{1'b0, 3'b101, 32'h2002, 32'h0, 32'h80010000, 1, 2, 3, 1,
                 32'h2000, 4'b1111, 32'h0, 32'h00008001, 1'b0, 2'b00};
    vecs[5]  = '{1'b0, 3'b001, 32'h2002, 32'h0, 32'h80010000, 1, 2, 3, 1,
                 32'h2000, 4'b1111, 32'h0, 32'hFFFF8001, 1'b0, 2'b00};
    vecs[6]  = '{1'b0, 3'b010, 32'h3000, 32'h0, 32'hDEADBEEF, 1, 2, 3, 1,
                 32'h3000, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0, 2'b00};
    vecs[7]  = '{1'b1, 3'b001, 32'h4002, 32'h1234ABCD, 32'h0, 1, 0, 2, 1,
                 32'h4000, 4'b1100, 32'hABCDABCD, 32'hDEADBEEF, 1'b0, 2'b00};
    vecs[8]  = '{1'b1, 3'b010, 32'h5004, 32'hCAFEF00D, 32'h0, 1, 0, 2, 1,
                 32'h5004, 4'b1111, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0, 2'b00};
    vecs[9]  = '{1'b0, 3'b010, 32'h3001, 32'h0, 32'h0, 0, 0, 1, 0,
                 32'h0, 4'b0, 32'h0, 32'hDEADBEEF, 1'b1, 2'b01};
    vecs[10] = '{1'b0, 3'b011, 32'h3000, 32'h0, 32'h0, 0, 0, 1, 0,
                 32'h0, 4'b0, 32'h0, 32'hDEADBEEF, 1'b1, 2'b10};
    vecs[11] = '{1'b0, 3'b001, 32'h2001, 32'h0, 32'h0, 0, 0, 1, 0,
                 32'h0, 4'b0, 32'h0, 32'hDEADBEEF, 1'b1, 2'b01};
    vecs[12] = '{1'b1, 3'b100, 32'h2000, 32'h55, 32'h0, 0, 0, 1, 0,
                 32'h0, 4'b0, 32'h0, 32'hDEADBEEF, 1'b1, 2'b10};
    vecs[13] = '{1'b0, 3'b000, 32'h6001, 32'h0, 32'h00007F00, 5, 7, 8, 5,
                 32'h6000, 4'b1111, 32'h0, 32'h0000007F, 1'b0, 2'b00};
    vecs[14] = '{1'b0, 3'b010, 32'h7000, 32'h0, 32'h0, 0, 0, 9, 8,
                 32'h7000, 4'b1111, 32'h0, 32'h0, 1'b1, 2'b11};

    // Reset values.
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_we_done_fault", {28'd0, dmem_req, dmem_we, done, fault}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_be_cause", {26'd0, dmem_be, fault_cause}, 32'd0);
    chk("rst_stall_state", {29'd0, stall, dbg_state}, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Random byte/word-lane loads against a small extraction model.
    for (int k = 0; k < 8; k++) begin
      off = $urandom_range(0, 3);
      sgn = 1'($urandom_range(0, 1));
      rd  = $urandom;
      b   = 8'(rd >> (8 * off));
      rv.st       = 1'b0;
      rv.f3       = sgn ? 3'b000 : 3'b100;
      rv.addr     = {16'h00A0, 8'($urandom_range(0, 255)), 6'd0, 2'(off)};
      rv.rs2      = 32'd0;
      rv.rdata    = rd;
      rv.gnt_cyc  = $urandom_range(1, 3);
      rv.rv_cyc   = rv.gnt_cyc + $urandom_range(1, 2);
      rv.done_cyc = rv.rv_cyc + 1;
      rv.req_cyc  = rv.gnt_cyc;
      rv.e_addr   = {rv.addr[31:2], 2'b00};
      rv.e_be     = 4'b1111;
      rv.e_wdata  = 32'd0;
      rv.e_load   = sgn ? {{24{b[7]}}, b} : {24'd0, b};
      rv.e_fault  = 1'b0;
      rv.e_cause  = 2'b00;
      run_vec(rv);
    end

    // Reset while a request is pending in REQ.
    drive_access(1'b1, 3'b010, 32'h9000, 32'h11223344);
    @(posedge clk);
    #1 ex_valid = 1'b0;
    mem_write   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_req_held", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_in_req_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_in_req_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Make load_data non-zero, then reset in WAIT_R and return a late response.
    run_vec(vecs[6]);
    drive_access(1'b0, 3'b010, 32'h8000, 32'h0);
    @(posedge clk);
    #1 ex_valid = 1'b0;
    mem_read    = 1'b0;
    @(negedge clk);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("pre_rst_wait_r", {30'd0, dbg_state}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rst_in_wait_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_in_wait_stall", {31'd0, stall}, 32'd0);
    chk("rst_in_wait_load", load_data, 32'd0);
    chk("rst_in_wait_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    late_done = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      dmem_rvalid = (c < 2);
      dmem_rdata  = 32'hFFFFFFFF;
      if (done || fault) late_done++;
    end
    dmem_rvalid = 1'b0;
    @(negedge clk);
    if (done || fault) late_done++;
    chk("late_rvalid_ignored", late_done, 0);
    chk("late_rvalid_load", load_data, 32'd0);
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
